// File: rtl/entrada_pkg.sv
// Shared types and defaults for the input-sequencing block that feeds the
// sequential multiplier.
package entrada_pkg;

  localparam int ANCHO_OP_DEF = 8;
  localparam int TIMEOUT_DEF  = 1024;

  // State encoding is exposed on the estado port for LEDs/debug, so the
  // values are fixed explicitly.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURA = 3'd1,
    LANZAR  = 3'd2,
    ESPERA  = 3'd3,
    HECHO   = 3'd4,
    FALLA   = 3'd5
  } estado_t;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for an already-debounced level signal.
// The reset value of the history register is a parameter: resetting it to 1
// means a button held down through reset does not produce an edge.
module detector_flanco #(
  parameter logic PREV_RST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic flanco
);

  logic prev;

  // History register: last cycle's level of the input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= PREV_RST;
    else        prev <= entrada;
  end

  assign flanco = entrada & ~prev;

endmodule

// File: rtl/control_entrada_mult.sv
// Sequencer between the button debouncer and the sequential multiplier:
// captures both operands on a load edge, launches the multiplier, waits for
// completion under a timeout and holds the product for display.
// Optional build macro OPERANDO_CERO_EN: a zero operand skips the multiplier
// and reports a zero product directly from LANZAR.
module control_entrada_mult
  import entrada_pkg::*;
#(
  parameter int ANCHO_OP = ANCHO_OP_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*ANCHO_OP-1:0] deb_botones,
  input  logic                  btn_cargar,
  output logic                  deb_enable,
  output logic                  mult_start,
  input  logic                  mult_done,
  input  logic [2*ANCHO_OP-1:0] mult_producto,
  output logic [ANCHO_OP-1:0]   op_a,
  output logic [ANCHO_OP-1:0]   op_b,
  output logic [2*ANCHO_OP-1:0] resultado,
  output logic                  listo,
  output logic                  ocupado,
  output logic                  error,
  output logic [2:0]            estado
);

  localparam int            CW         = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CUENTA_MAX = CW'(TIMEOUT - 1);

  estado_t       estado_q, estado_sig;
  logic [CW-1:0] cuenta;
  logic          carga_ev;
  logic          op_cero;

  detector_flanco #(.PREV_RST(1'b1)) u_flanco_carga (
    .clk    (clk),
    .reset  (reset),
    .entrada(btn_cargar),
    .flanco (carga_ev)
  );

`ifdef OPERANDO_CERO_EN
  assign op_cero = (op_a == '0) || (op_b == '0);
`else
  assign op_cero = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values, independent of block ordering.
    if (!reset) estado_q <= IDLE;
    else        estado_q <= estado_sig;
  end

  // Next-state logic; load edges outside IDLE/HECHO/FALLA are simply dropped.
  always_comb begin
    // NOTE: default first, so every path assigns estado_sig and no latch forms.
    estado_sig = estado_q;
    case (estado_q)
      IDLE:    if (carga_ev) estado_sig = CAPTURA;
      CAPTURA: estado_sig = LANZAR;
      LANZAR:  estado_sig = op_cero ? HECHO : ESPERA;
      ESPERA: begin
        // Completion wins over a timeout landing on the same cycle.
        if (mult_done)                estado_sig = HECHO;
        else if (cuenta == CUENTA_MAX) estado_sig = FALLA;
      end
      HECHO:   if (carga_ev) estado_sig = CAPTURA;
      FALLA:   if (carga_ev) estado_sig = CAPTURA;
      default: estado_sig = IDLE;
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    deb_enable = (estado_q == IDLE) || (estado_q == HECHO) || (estado_q == FALLA);
    mult_start = (estado_q == LANZAR) && !op_cero;
    listo      = (estado_q == HECHO);
    ocupado    = (estado_q == CAPTURA) || (estado_q == LANZAR) || (estado_q == ESPERA);
    error      = (estado_q == FALLA);
    estado     = estado_q;
  end

  // Operand capture, timeout counter and product register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a      <= '0;
      op_b      <= '0;
      resultado <= '0;
      cuenta    <= '0;
    end else begin
      case (estado_q)
        CAPTURA: begin
          op_a <= deb_botones[ANCHO_OP-1:0];
          op_b <= deb_botones[2*ANCHO_OP-1:ANCHO_OP];
        end
        LANZAR: begin
          cuenta <= '0;
          if (op_cero) resultado <= '0;
        end
        ESPERA: begin
          if (mult_done)                resultado <= mult_producto;
          else if (cuenta != CUENTA_MAX) cuenta    <= cuenta + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_entrada_mult.sv
// Randomised scoreboard bench for control_entrada_mult with a small
// multiplier responder model.
`timescale 1ns/1ps
module tb_control_entrada_mult;
  import entrada_pkg::*;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] deb_botones;
  logic        btn_cargar;
  logic        deb_enable, mult_start, mult_done;
  logic [15:0] mult_producto;
  logic [7:0]  op_a, op_b;
  logic [15:0] resultado;
  logic        listo, ocupado, error;
  logic [2:0]  estado;

  logic        resp_done, stim_done;
  logic [15:0] resp_prod;
  assign mult_done     = resp_done | stim_done;
  assign mult_producto = resp_prod;

  control_entrada_mult #(.ANCHO_OP(8), .TIMEOUT(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .deb_botones  (deb_botones),
    .btn_cargar   (btn_cargar),
    .deb_enable   (deb_enable),
    .mult_start   (mult_start),
    .mult_done    (mult_done),
    .mult_producto(mult_producto),
    .op_a         (op_a),
    .op_b         (op_b),
    .resultado    (resultado),
    .listo        (listo),
    .ocupado      (ocupado),
    .error        (error),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
  } start_t;

  typedef struct {
    bit          err;
    logic [15:0] res;
    int          cyc;
  } res_t;

  start_t exp_start[$];
  res_t   exp_res[$];
  logic [15:0] last_res = 16'h0;
  int resp_lat = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier model: answers each start with a*b after resp_lat cycles.
  int          r_l;
  logic [15:0] r_p;
  initial begin
    resp_done = 1'b0;
    resp_prod = 16'h0;
    forever begin
      @(negedge clk);
      if (mult_start === 1'b1 && resp_lat >= 0) begin
        r_l = resp_lat;
        r_p = {8'd0, op_a} * {8'd0, op_b};
        repeat (r_l) @(negedge clk);
        resp_done = 1'b1;
        resp_prod = r_p;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  // Monitor: pops expected events whenever the DUT presents one.
  logic   m_prev_start = 1'b0, m_prev_listo = 1'b0, m_prev_err = 1'b0;
  start_t m_s;
  res_t   m_r;
  initial begin
    forever begin
      @(negedge clk);
      if (mult_start === 1'b1) begin
        check("start_single_cycle", m_prev_start, 1'b0);
        check("start_expected", exp_start.size() > 0, 1'b1);
        if (exp_start.size() > 0) begin
          m_s = exp_start.pop_front();
          check("start_cycle", cyc, m_s.cyc);
          check("op_a", op_a, m_s.a);
          check("op_b", op_b, m_s.b);
        end
      end
      if ((listo === 1'b1 && !m_prev_listo) || (error === 1'b1 && !m_prev_err)) begin
        check("outcome_expected", exp_res.size() > 0, 1'b1);
        if (exp_res.size() > 0) begin
          m_r = exp_res.pop_front();
          check("outcome_is_error", error, m_r.err);
          check("outcome_listo", listo, !m_r.err);
          check("outcome_resultado", resultado, m_r.res);
          check("outcome_cycle", cyc, m_r.cyc);
        end
      end
      m_prev_start = mult_start;
      m_prev_listo = listo;
      m_prev_err   = error;
    end
  end

  // Issue one load edge with operands a/b; lat<0 means the multiplier never answers.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input int lat);
    int     c;
    bit     zero;
    start_t st;
    res_t   rt;
    @(negedge clk);
    deb_botones = {b, a};
    btn_cargar  = 1'b1;
    resp_lat    = lat;
    c           = cyc;
    zero        = 1'b0;
`ifdef OPERANDO_CERO_EN
    zero = (a == 8'h00) || (b == 8'h00);
`endif
    if (zero) begin
      last_res = 16'h0;
      rt.err = 1'b0; rt.res = 16'h0; rt.cyc = c + 3;
    end else begin
      st.cyc = c + 2; st.a = a; st.b = b;
      exp_start.push_back(st);
      if (lat >= 1 && lat <= T) begin
        last_res = 16'(a) * 16'(b);
        rt.err = 1'b0; rt.res = last_res; rt.cyc = c + lat + 3;
      end else begin
        rt.err = 1'b1; rt.res = last_res; rt.cyc = c + T + 3;
      end
    end
    exp_res.push_back(rt);
    @(negedge clk);
    check("enter_captura", estado, CAPTURA);
    check("captura_listo_low", listo, 1'b0);
    check("captura_error_low", error, 1'b0);
    check("captura_deb_enable", deb_enable, 1'b0);
    btn_cargar = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_start.size() != 0 || exp_res.size() != 0) && n < 4 * T + 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", exp_start.size() + exp_res.size(), 0);
    exp_start.delete();
    exp_res.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] ra, rb;
  int         rl;
  initial begin
    reset       = 1'b0;
    btn_cargar  = 1'b1;
    deb_botones = 16'h0;
    stim_done   = 1'b0;

    // Button held through reset and release must not fire.
    repeat (3) @(negedge clk);
    check("rst_estado", estado, IDLE);
    check("rst_deb_enable", deb_enable, 1'b1);
    check("rst_outputs", {mult_start, listo, ocupado, error}, 4'b0);
    check("rst_regs", {op_a, op_b, resultado}, 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("held_btn_estado", estado, IDLE);
    check("held_btn_deb_enable", deb_enable, 1'b1);
    btn_cargar = 1'b0;
    repeat (2) @(negedge clk);

    // Directed load: 0x05 * 0x0C.
    launch(8'h05, 8'h0C, 8);
    wait_drain();
    check("dir_resultado", resultado, 16'h003C);
    check("dir_listo", listo, 1'b1);

    // Timeout, then recovery and boundary latencies.
    launch(8'h21, 8'h03, -1);
    wait_drain();
    check("to_error", error, 1'b1);
    check("to_resultado_held", resultado, 16'h003C);
    launch(8'h03, 8'h04, T);
    wait_drain();
    launch(8'h07, 8'h09, T + 1);
    wait_drain();
    launch(8'h02, 8'h02, T - 1);
    wait_drain();

    // Load edges during ESPERA are dropped.
    launch(8'h11, 8'h22, 15);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      btn_cargar = 1'b1;
      @(negedge clk);
      btn_cargar = 1'b0;
      @(negedge clk);
      check("espera_ignores_load", estado, ESPERA);
    end
    wait_drain();
    // Stray done in HECHO is ignored.
    stim_done = 1'b1;
    @(negedge clk);
    stim_done = 1'b0;
    @(negedge clk);
    check("hecho_ignores_done", estado, HECHO);
    check("hecho_resultado", resultado, last_res);

    // Async reset mid-ESPERA.
    launch(8'h03, 8'h05, -1);
    repeat (5) @(negedge clk);
    check("pre_reset_espera", estado, ESPERA);
    #2 reset = 1'b0;
    #1;
    check("midrst_estado", estado, IDLE);
    check("midrst_deb_enable", deb_enable, 1'b1);
    check("midrst_outputs", {mult_start, listo, ocupado, error}, 4'b0);
    check("midrst_regs", {op_a, op_b, resultado}, 32'h0);
    exp_start.delete();
    exp_res.delete();
    last_res = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    stim_done = 1'b1;
    @(negedge clk);
    stim_done = 1'b0;
    @(negedge clk);
    check("idle_ignores_done", estado, IDLE);
    check("idle_listo_low", listo, 1'b0);

    // Zero operands.
    launch(8'h00, 8'h07, 5);
    wait_drain();
    check("zero_resultado", resultado, 16'h0);
    launch(8'h09, 8'h00, 3);
    wait_drain();

    // Randomised transactions.
    for (int k = 0; k < 25; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      rl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, T + 1));
      launch(ra, rb, rl);
      wait_drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
